// File: rtl/target_uart_relay_if.sv
// Target-to-host UART relay bus: line pins, release gate and RX/FIFO status.
// The relay drives the slave side; the host-side logic or bench drives the master side.
interface target_uart_relay_if #(
  parameter int FIFO_AW = 4
);
  logic             din;
  logic             dout;
  logic             tx_release;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             frame_err;
  logic             overflow;
  logic [FIFO_AW:0] fifo_level;
  logic             break_det;

  modport master (
    output din, tx_release,
    input  dout, rx_valid, rx_data, frame_err,
    input  overflow, fifo_level, break_det
  );

  modport slave (
    input  din, tx_release,
    output dout, rx_valid, rx_data, frame_err,
    output overflow, fifo_level, break_det
  );
endinterface

// File: rtl/target_uart_relay.sv
// Target UART relay: 8N1 RX -> byte FIFO -> gated 8N1 TX back to the host.
// Optional line-break detector enabled by defining RELAY_BREAK_DET_EN.
module target_uart_relay #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input logic                clk,
  input logic                rst,
  target_uart_relay_if.slave bus
);
  localparam int CW = $clog2(10 * CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_STOP, R_BRK
  } rx_st_t;

  typedef enum logic [1:0] {
    T_IDLE, T_START, T_DATA, T_STOP
  } tx_st_t;

  logic s1, s2, s3, fall;
  rx_st_t        rx_st;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh, rx_data;
  logic          rx_valid, frame_err;
  logic          brk_hold, break_det;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   level;
  logic             full, wr_ok, rd_req, overflow;

  tx_st_t        tx_st;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh;
  logic          dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      {s1, s2, s3} <= 3'b111;
    end else begin
      s1 <= bus.din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall = s3 & ~s2;

`ifdef RELAY_BREAK_DET_EN
  localparam logic [CW-1:0] BRK_LEN = CW'(10 * CLKS_PER_BIT);
  localparam logic [CW-1:0] BRK_END = CW'(10 * CLKS_PER_BIT - 1);

  logic [CW-1:0] brk_cnt, hi_cnt;
  logic          brk_hit;

  assign brk_hit = ~s2 && (brk_cnt == BRK_END);

  // brk_cnt saturates so a long break reports only once
  always_ff @(posedge clk) begin
    if (rst) begin
      brk_cnt   <= '0;
      hi_cnt    <= '0;
      brk_hold  <= 1'b0;
      break_det <= 1'b0;
    end else begin
      break_det <= brk_hit;
      if (s2)
        brk_cnt <= '0;
      else if (brk_cnt != BRK_LEN)
        brk_cnt <= brk_cnt + CW'(1);
      if (brk_hit) begin
        brk_hold <= 1'b1;
        hi_cnt   <= '0;
      end else if (brk_hold) begin
        if (!s2)
          hi_cnt <= '0;
        else if (hi_cnt == BIT_END)
          brk_hold <= 1'b0;
        else
          hi_cnt <= hi_cnt + CW'(1);
      end
    end
  end
`else
  assign brk_hold  = 1'b0;
  assign break_det = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st     <= R_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_sh     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      unique case (rx_st)
        R_IDLE: begin
          rx_cnt <= '0;
          if (fall && !brk_hold)
            rx_st <= R_START;
        end
        R_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_st  <= s2 ? R_IDLE : R_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        R_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            rx_sh  <= {s2, rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7)
              rx_st <= R_STOP;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        R_STOP: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            rx_st  <= R_IDLE;
            if (s2) begin
              rx_data  <= rx_sh;
              rx_valid <= 1'b1;
`ifdef RELAY_BREAK_DET_EN
            end else if (rx_sh == 8'h00) begin
              rx_st <= R_BRK;
`endif
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        R_BRK: begin
`ifdef RELAY_BREAK_DET_EN
          // all-zero frame: a break if the line stays low, else a framing error
          if (brk_hit) begin
            rx_st <= R_IDLE;
          end else if (s2) begin
            frame_err <= 1'b1;
            rx_st     <= R_IDLE;
          end
`else
          rx_st <= R_IDLE;
`endif
        end
        default: rx_st <= R_IDLE;
      endcase
`ifdef RELAY_BREAK_DET_EN
      if (brk_hit)
        rx_st <= R_IDLE;
`endif
    end
  end

  assign full  = (level == (FIFO_AW + 1)'(FIFO_DEPTH));
  assign wr_ok = rx_valid && (!full || rd_req);

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_req)
        rd_ptr <= rd_ptr + 1'b1;
      if (rx_valid && full && !rd_req)
        overflow <= 1'b1;
      if (wr_ok && !rd_req)
        level <= level + 1'b1;
      else if (!wr_ok && rd_req)
        level <= level - 1'b1;
    end
  end

  // popping at the end of STOP keeps queued bytes back-to-back
  assign rd_req = bus.tx_release && (level != '0) &&
                  ((tx_st == T_IDLE) ||
                   (tx_st == T_STOP && tx_cnt == BIT_END));

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st  <= T_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
      dout   <= 1'b1;
    end else begin
      unique case (tx_st)
        T_IDLE: begin
          tx_cnt <= '0;
          if (rd_req) begin
            tx_sh <= mem[rd_ptr];
            dout  <= 1'b0;
            tx_st <= T_START;
          end
        end
        T_START: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            tx_bit <= '0;
            dout   <= tx_sh[0];
            tx_st  <= T_DATA;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        T_DATA: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            tx_bit <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) begin
              dout  <= 1'b1;
              tx_st <= T_STOP;
            end else begin
              dout  <= tx_sh[1];
              tx_sh <= tx_sh >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        T_STOP: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (rd_req) begin
              tx_sh <= mem[rd_ptr];
              dout  <= 1'b0;
              tx_st <= T_START;
            end else begin
              tx_st <= T_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: tx_st <= T_IDLE;
      endcase
    end
  end

  assign bus.dout       = dout;
  assign bus.rx_valid   = rx_valid;
  assign bus.rx_data    = rx_data;
  assign bus.frame_err  = frame_err;
  assign bus.overflow   = overflow;
  assign bus.fifo_level = level;
  assign bus.break_det  = break_det;
endmodule

// File: tb/tb_target_uart_relay.sv
// Scoreboard bench for target_uart_relay at CLKS_PER_BIT=16, FIFO_DEPTH=16.
// Define RELAY_BREAK_DET_EN to exercise the break detector build.
module tb_target_uart_relay;
  localparam int CPB = 16;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];
  int tx_starts[$];
  int rxv_cycles[$];
  int rxv_cnt = 0;
  int fe_cnt = 0;
  int bd_cnt = 0;

  target_uart_relay_if #(.FIFO_AW(AW)) bus ();

  target_uart_relay #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .FIFO_AW     (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (bus.frame_err) fe_cnt++;
      if (bus.break_det) bd_cnt++;
      if (bus.rx_valid) begin
        rxv_cnt++;
        rxv_cycles.push_back(cyc);
        if (rx_exp.size() != 0)
          check_eq("rx_data", bus.rx_data, rx_exp.pop_front());
        else
          check_eq("rx_unexpected", 1, 0);
      end
    end
  end

  initial begin
    logic prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev && !bus.dout) begin
        tx_starts.push_back(cyc);
        repeat (CPB / 2) @(negedge clk);
        check_eq("tx_start_bit", bus.dout, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = bus.dout;
        end
        repeat (CPB) @(negedge clk);
        check_eq("tx_stop_bit", bus.dout, 1);
        if (tx_exp.size() != 0)
          check_eq("tx_byte", b, tx_exp.pop_front());
        else
          check_eq("tx_unexpected", b, 9'h100);
      end
      prev = bus.dout;
    end
  end

  task automatic send(input logic [7:0] b, input logic stop);
    bus.din = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.din = b[i];
      repeat (CPB) @(posedge clk);
    end
    bus.din = stop;
    repeat (CPB) @(posedge clk);
    bus.din = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b, input bit to_host);
    rx_exp.push_back(b);
    if (to_host) tx_exp.push_back(b);
    send(b, 1'b1);
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while ((tx_exp.size() != 0 || bus.fifo_level != 0) && n < lim) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_in_time", n < lim, 1);
    repeat (20) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_dout"}, bus.dout, 1);
    check_eq({tag, "_rx_valid"}, bus.rx_valid, 0);
    check_eq({tag, "_frame_err"}, bus.frame_err, 0);
    check_eq({tag, "_overflow"}, bus.overflow, 0);
    check_eq({tag, "_level"}, bus.fifo_level, 0);
    check_eq({tag, "_rx_data"}, bus.rx_data, 0);
    check_eq({tag, "_break"}, bus.break_det, 0);
  endtask

  initial begin
    int lat, rv0, fe0, bd0, n;
    bus.din = 1'b1;
    bus.tx_release = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // back-to-back relay with release open
    bus.tx_release = 1'b1;
    tx_starts.delete();
    rxv_cycles.delete();
    send_good(8'h55, 1);
    send_good(8'hA3, 1);
    drain(600);
    if (tx_starts.size() >= 2 && rxv_cycles.size() >= 1) begin
      check_eq("frame_len", tx_starts[1] - tx_starts[0], 10 * CPB);
      lat = tx_starts[0] - rxv_cycles[0];
      check_eq("latency_le3", (lat >= 0) && (lat <= 3), 1);
    end else begin
      check_eq("t1_starts", tx_starts.size(), 2);
    end

    // hold then release five bytes
    bus.tx_release = 1'b0;
    for (int i = 1; i <= 5; i++) send_good(8'(i), 1);
    repeat (10) @(negedge clk);
    check_eq("held_level5", bus.fifo_level, 5);
    check_eq("held_dout", bus.dout, 1);
    bus.tx_release = 1'b1;
    drain(1200);
    check_eq("release_level0", bus.fifo_level, 0);

    // overflow: 17th byte dropped
    bus.tx_release = 1'b0;
    for (int i = 0; i < 17; i++) send_good(8'(8'h10 + i), i < DEPTH);
    repeat (10) @(negedge clk);
    check_eq("ovf_level", bus.fifo_level, DEPTH);
    check_eq("ovf_flag", bus.overflow, 1);
    bus.tx_release = 1'b1;
    drain(4000);
    repeat (200) @(negedge clk);
    check_eq("ovf_sticky", bus.overflow, 1);

    // bad stop bit
    rv0 = rxv_cnt;
    fe0 = fe_cnt;
    send(8'h3C, 1'b0);
    repeat (30) @(negedge clk);
    check_eq("ferr_pulse", fe_cnt - fe0, 1);
    check_eq("ferr_no_valid", rxv_cnt - rv0, 0);
    check_eq("ferr_level", bus.fifo_level, 0);

    // release dropped mid-frame
    bus.tx_release = 1'b0;
    send_good(8'h81, 1);
    send_good(8'h7E, 1);
    repeat (5) @(negedge clk);
    bus.tx_release = 1'b1;
    n = 0;
    while (bus.dout && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("t5_start_seen", n < 10, 1);
    repeat (5) @(negedge clk);
    bus.tx_release = 1'b0;
    repeat (400) @(negedge clk);
    check_eq("t5_held_level", bus.fifo_level, 1);
    check_eq("t5_held_q", tx_exp.size(), 1);
    bus.tx_release = 1'b1;
    drain(600);

    // short glitch on the line
    rv0 = rxv_cnt;
    fe0 = fe_cnt;
    bd0 = bd_cnt;
    bus.din = 1'b0;
    repeat (6) @(posedge clk);
    bus.din = 1'b1;
    repeat (100) @(negedge clk);
    check_eq("glitch_pulses", (rxv_cnt - rv0) + (fe_cnt - fe0) + (bd_cnt - bd0), 0);

    // long break
    fe0 = fe_cnt;
    bd0 = bd_cnt;
    rv0 = rxv_cnt;
    bus.din = 1'b0;
    repeat (200) @(posedge clk);
    bus.din = 1'b1;
    repeat (60) @(negedge clk);
`ifdef RELAY_BREAK_DET_EN
    check_eq("brk_det", bd_cnt - bd0, 1);
    check_eq("brk_no_ferr", fe_cnt - fe0, 0);
`else
    check_eq("brk_det_off", bd_cnt - bd0, 0);
    check_eq("brk_ferr", fe_cnt - fe0, 1);
`endif
    check_eq("brk_no_valid", rxv_cnt - rv0, 0);
    check_eq("brk_level", bus.fifo_level, 0);

    // reset mid-RX discards FIFO and partial frame
    bus.tx_release = 1'b0;
    send_good(8'h99, 0);
    repeat (5) @(negedge clk);
    check_eq("pre_rst_level", bus.fifo_level, 1);
    bus.din = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("mid_rst");
    bus.din = 1'b1;
    rst = 1'b0;
    bus.tx_release = 1'b1;
    repeat (300) @(negedge clk);
    check_eq("post_rst_level", bus.fifo_level, 0);
    send_good(8'hC6, 1);
    drain(600);
    check_eq("rx_q_empty", rx_exp.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
